// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream to instruction-memory loader
//
// Assembles a valid/ready byte stream into little-endian 32-bit words and
// writes them to instruction memory at consecutive word addresses from 0.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             begin a load (sampled in IDLE only)
//   i_num_words         number of words to load, sampled with i_start
//   i_byte_valid/i_byte stream input
//   o_byte_ready        loader accepts a byte this cycle (RECV)
//   o_we/o_waddr/o_wdata instruction memory write port
//   o_busy              load in progress (RECV, WRITE, DONE)
//   o_done              one-cycle pulse on completion
//   o_error             one-cycle pulse on a rejected start
module instruction_loader #(
    parameter int MEM_SIZE   = 1024,
    parameter int AW         = $clog2(MEM_SIZE),
    parameter int NW         = $clog2(MEM_SIZE / 4) + 1,
    parameter int INST_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NW-1:0]         i_num_words,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_we,
    output logic [AW-1:0]         o_waddr,
    output logic [INST_WIDTH-1:0] o_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [NW-1:0] MAX_WORDS = NW'(MEM_SIZE / 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [NW-1:0]           count_q;
    logic [NW-1:0]           word_cnt_q;
    logic [AW-1:0]           addr_q;
    logic [1:0]              byte_idx_q;
    logic [INST_WIDTH-1:0]   asm_q;
    logic                    error_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_num_words > MAX_WORDS) begin
                            error_q <= 1'b1;
                        end else if (i_num_words == '0) begin
                            state_q <= DONE;
                        end else begin
                            count_q    <= i_num_words;
                            word_cnt_q <= '0;
                            addr_q     <= '0;
                            byte_idx_q <= '0;
                            state_q    <= RECV;
                        end
                    end
                end
                RECV: begin
                    // Ready is constant in RECV, so valid alone marks acceptance.
                    if (i_byte_valid) begin
                        asm_q[{byte_idx_q, 3'b000} +: 8] <= i_byte;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    addr_q     <= addr_q + AW'(4);
                    word_cnt_q <= word_cnt_q + NW'(1);
                    byte_idx_q <= '0;
                    state_q    <= (word_cnt_q + NW'(1) == count_q) ? DONE : RECV;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign o_byte_ready = (state_q == RECV);
    assign o_we         = (state_q == WRITE);
    assign o_done       = (state_q == DONE);
    assign o_busy       = (state_q != IDLE);
    assign o_error      = error_q;
    assign o_waddr      = addr_q;
    assign o_wdata      = asm_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader
module tb_instruction_loader;
    localparam int MEM_SIZE = 1024;
    localparam int AW = 10;
    localparam int NW = 9;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [NW-1:0] i_num_words = '0;
    logic          i_byte_valid = 1'b0;
    logic [7:0]    i_byte = '0;
    logic          o_byte_ready;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [31:0]   o_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    instruction_loader #(.MEM_SIZE(MEM_SIZE)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_words(i_num_words),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 error
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         sb[$];
    logic [7:0]  bq[$];
    logic [31:0] mem[256];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_we = 0;
    bit have_we = 0;
    bit strict = 0;
    bit busy_chk = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind %0d addr %h data %h, none expected", kind, addr, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (kind == 0 && (e.addr != addr || e.data != data))) begin
                n_err++;
                $display("FAIL event: got kind %0d %h@%h expected kind %0d %h@%h",
                         kind, data, addr, e.kind, e.data, e.addr);
            end
        end
    endfunction

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge i_clk) begin
        if (busy_chk) begin
            check("busy_after_done", {31'd0, o_busy}, 32'd0);
            busy_chk = 0;
        end
        if (o_we === 1'b1) begin
            check("we_while_ready", {31'd0, o_byte_ready}, 32'd0);
            expect_ev(0, {22'd0, o_waddr}, o_wdata);
            mem[o_waddr[AW-1:2]] = o_wdata;
            if (strict && have_we) check("we_spacing", cyc - last_we, 32'd5);
            last_we = cyc;
            have_we = 1;
        end
        if (o_done === 1'b1) begin
            expect_ev(1, 0, 0);
            check("done_busy", {31'd0, o_busy}, 32'd1);
            if (have_we) check("done_after_we", cyc - last_we, 32'd1);
            busy_chk = 1;
        end
        if (o_error === 1'b1) begin
            expect_ev(2, 0, 0);
            check("error_busy", {31'd0, o_busy}, 32'd0);
        end
    end

    // Reference model: word i is bytes 4i..4i+3, little-endian, at byte address 4i.
    task automatic push_model(input int n);
        ev_t e;
        if (n > MEM_SIZE / 4) begin
            e.kind = 2; e.addr = 0; e.data = 0; sb.push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.kind = 0;
                e.addr = 4 * i;
                e.data = 32'(bq[4*i]) + (32'(bq[4*i+1]) << 8) + (32'(bq[4*i+2]) << 16) + (32'(bq[4*i+3]) << 24);
                sb.push_back(e);
            end
            e.kind = 1; e.addr = 0; e.data = 0; sb.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'd0, o_byte_ready}, 0);
        check({tag, "_we"},    {31'd0, o_we}, 0);
        check({tag, "_waddr"}, {22'd0, o_waddr}, 0);
        check({tag, "_wdata"}, o_wdata, 0);
        check({tag, "_busy"},  {31'd0, o_busy}, 0);
        check({tag, "_done"},  {31'd0, o_done}, 0);
        check({tag, "_error"}, {31'd0, o_error}, 0);
    endtask

    task automatic do_start(input int n);
        have_we = 0;
        i_start = 1'b1;
        i_num_words = NW'(n);
        @(negedge i_clk);
        i_start = 1'b0;
        if (n > MEM_SIZE / 4) begin
            check("reject_error", {31'd0, o_error}, 1);
            check("reject_busy", {31'd0, o_busy}, 0);
        end else if (n == 0) begin
            check("zero_done", {31'd0, o_done}, 1);
            check("zero_busy", {31'd0, o_busy}, 1);
        end else begin
            check("start_busy", {31'd0, o_busy}, 1);
            check("start_ready", {31'd0, o_byte_ready}, 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte = b;
        t = 0;
        while (o_byte_ready !== 1'b1 && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (o_byte_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL byte_timeout: ready %b expected 1", o_byte_ready);
        end
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || o_busy !== 1'b0) && t < 4000) begin
            @(negedge i_clk);
            t++;
        end
        check("idle_pending", sb.size(), 0);
        check("idle_busy", {31'd0, o_busy}, 0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic run_load(input int n, input int gapmax);
        push_model(n);
        do_start(n);
        if (n >= 1 && n <= MEM_SIZE / 4)
            for (int i = 0; i < 4 * n; i++)
                send_byte(bq[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        wait_idle();
    endtask

    initial begin
        logic [7:0] basic[16];
        basic = '{8'h13, 8'h81, 8'h10, 8'h00, 8'h93, 8'h81, 8'h10, 8'h00,
                  8'h33, 8'h02, 8'h31, 8'h00, 8'he3, 8'h8a, 8'h21, 8'hfe};

        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic load, stream fully valid
        bq.delete();
        for (int i = 0; i < 16; i++) bq.push_back(basic[i]);
        strict = 1;
        run_load(4, 0);
        strict = 0;
        check("mem0", mem[0], 32'h00108113);
        check("mem1", mem[1], 32'h00108193);
        check("mem2", mem[2], 32'h00310233);
        check("mem3", mem[3], 32'hfe218ae3);

        // Same stream with random gaps
        run_load(4, 3);

        // Bounds
        run_load(0, 0);
        run_load(257, 0);
        bq.delete();
        for (int i = 0; i < 1024; i++) bq.push_back(8'($urandom));
        run_load(256, 0);
        check("mem_last", mem[255], {bq[1023], bq[1022], bq[1021], bq[1020]});

        // Ignored start during RECV
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        push_model(2);
        do_start(2);
        send_byte(bq[0], 0);
        i_start = 1'b1;
        i_num_words = NW'(9);
        @(negedge i_clk);
        i_start = 1'b0;
        check("ignored_ready", {31'd0, o_byte_ready}, 1);
        for (int i = 1; i < 8; i++) send_byte(bq[i], 0);
        wait_idle();

        // Reset mid-word
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        push_model(1);
        void'(sb.pop_back());            // load is aborted: no done expected
        do_start(2);
        for (int i = 0; i < 7; i++) send_byte(bq[i], 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_all_zero("midreset");
        check("midreset_pending", sb.size(), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        bq.delete();
        bq.push_back(8'h78); bq.push_back(8'h56); bq.push_back(8'h34); bq.push_back(8'h12);
        run_load(1, 0);
        check("reset_reload", mem[0], 32'h12345678);

        // Random loads
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(8, 1));
            bq.delete();
            for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
            run_load(n, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Write-side companion to `instruction_memory`. It accepts a byte stream from a host or boot source over a valid/ready handshake and assembles each group of four bytes into a little-endian 32-bit instruction. Each completed word is written into instruction memory at consecutive word addresses starting at 0. While a load is in progress it holds the CPU off via `o_busy`, and it pulses `o_done` when the requested number of words has been written.

## Interface

Parameters:
- `MEM_SIZE`, default 1024: instruction memory size in bytes.
- `AW`, default `$clog2(MEM_SIZE)`: byte address width.
- `NW`, default `$clog2(MEM_SIZE/4)+1`: word-count width, wide enough to express a full memory.

Ports:
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_start`, input, 1: begin a load; sampled only in IDLE.
- `i_num_words`, input, NW: number of words to load; sampled with `i_start`.
- `i_byte_valid`, input, 1: `i_byte` holds a valid byte.
- `i_byte`, input, 8: stream byte.
- `o_byte_ready`, output, 1: loader accepts a byte this cycle.
- `o_we`, output, 1: instruction memory write enable; one-cycle pulse per word.
- `o_waddr`, output, AW: write byte address; bits [1:0] are always 0.
- `o_wdata`, output, `INST_WIDTH`: assembled instruction.
- `o_busy`, output, 1: load in progress; the CPU is held in reset while high.
- `o_done`, output, 1: one-cycle pulse when a load completes.
- `o_error`, output, 1: one-cycle pulse when a start request is rejected.

## Operation

- The FSM has four states: IDLE, RECV, WRITE and DONE.
- In IDLE with `i_start`=1:
  - If `i_num_words` > MEM_SIZE/4: pulse `o_error` next cycle, stay in IDLE, no writes.
  - Else if `i_num_words` == 0: go to DONE, no writes.
  - Otherwise latch the count, clear the word counter, address and byte index, and go to RECV.
- RECV:
  - `o_byte_ready`=1.
  - A byte is accepted on an edge where `i_byte_valid & o_byte_ready`.
  - Byte k (k = 0..3) goes into bits [8k+7:8k] of the assembly register; byte index 0 is the LSB (RISC-V little-endian).
  - After byte 3 is accepted, go to WRITE.
  - Cycles with `i_byte_valid`=0 leave the state unchanged.
- WRITE:
  - `o_we`=1, `o_waddr` = current address, `o_wdata` = assembled word, `o_byte_ready`=0.
  - On exit the address advances by 4, the word counter increments and the byte index clears.
  - If the word just written was the last, go to DONE; otherwise go to RECV.
- DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- `o_busy`=1 in RECV, WRITE and DONE; 0 in IDLE.
- `i_start` outside IDLE is ignored. No restart or abort except by reset.
- Address arithmetic is AW-bit unsigned. No wrap can occur because of the start check; the highest address written is MEM_SIZE-4.
- `o_wdata` and `o_waddr` are don't-care while `o_we`=0. They are driven from registers and must be stable throughout the WRITE cycle.

## Timing

- Reset (synchronous, takes effect on the edge where `i_rst`=1):
  - State goes to IDLE; address, counters and assembly register clear to 0.
  - All outputs read 0: `o_byte_ready`, `o_we`, `o_waddr`, `o_wdata`, `o_busy`, `o_done`, `o_error`.
- Reset mid-operation discards any partial word. Writes already performed remain in memory. The next load starts again at address 0.
- `i_rst` has priority over `i_start` and byte acceptance in the same cycle.
- Start latency: `i_start` sampled at edge N gives `o_busy`=1 and `o_byte_ready`=1 in cycle N+1.
- Per word:
  - The 4th byte is accepted at edge M, so WRITE (`o_we`=1) occurs in cycle M+1.
  - RECV resumes in cycle M+2.
  - With the stream fully valid, throughput is 5 cycles per word.
- Completion: the last WRITE is in cycle W, `o_done`=1 in cycle W+1, and `o_busy` drops to 0 in cycle W+2.
- Zero-length start at edge N: `o_done`=1 and `o_busy`=1 in cycle N+1, then IDLE.
- Rejected start at edge N: `o_error`=1 in cycle N+1, `o_busy` stays 0.
- `o_byte_ready` depends only on state, never combinationally on `i_byte_valid`.

## Test plan

- **Basic load:** start with `i_num_words`=4, stream bytes 13 81 10 00 93 81 10 00 33 02 31 00 e3 8a 21 fe with valid held high.
  - Required: four `o_we` pulses writing 00108113@000, 00108193@004, 00310233@008 and fe218ae3@00c, each pulse 5 cycles apart.
  - Required: `o_done` pulse 1 cycle after the last write.
  - Required: a memory readback via `instruction_memory` matches.
- **Backpressure gaps:** same stream with `i_byte_valid` deasserted for 0–3 random cycles between bytes.
  - Required: identical writes and data; no byte is dropped or duplicated.
  - Required: `o_we` never asserts while `o_byte_ready`=1.
- **Bounds:**
  - `i_num_words`=0: `o_done` next cycle, no `o_we`.
  - `i_num_words`=257 (MEM_SIZE=1024): `o_error` pulse, `o_busy` stays 0.
  - `i_num_words`=256: the last write is at address 3fc, then `o_done`.
- **Ignored start:** assert `i_start` with `i_num_words`=9 during RECV of a 2-word load.
  - Required: exactly 2 writes (000 and 004), then `o_done`.
- **Reset mid-word:** assert `i_rst` after byte 2 of word 1, then start a new 1-word load with bytes 78 56 34 12.
  - Required: all outputs 0 on the cycle after reset.
  - Required: a single write of 12345678@000.
